// File: rtl/stream_width_upsizer.sv
// -----------------------------------------------------------------------------
// stream_width_upsizer
//   Packs a narrow AXI4-Stream into a wide one, RATIO input beats per output
//   word, lowest lane first. A group closes on tlast or when the top lane is
//   filled. The closing beat bypasses the accumulator straight into a
//   registered output stage, so back-to-back groups run with no input bubbles
//   while m_axis_tready is held high.
//
// Ports
//   clk, reset      clock; synchronous active-high reset
//   s_axis_tdata    input beat data (INPUT_WIDTH)
//   s_axis_tkeep    valid-byte count of a last beat, 0 = all bytes
//   s_axis_tvalid   input valid
//   s_axis_tready   input ready = !m_axis_tvalid || m_axis_tready
//   s_axis_tuser    input sideband
//   s_axis_tlast    last beat of packet
//   m_axis_tdata    packed word (INPUT_WIDTH*RATIO), unused upper lanes are 0
//   m_axis_tkeep    valid-byte count of a tlast word, 0 = all bytes
//   m_axis_tvalid   output valid
//   m_axis_tready   output ready
//   m_axis_tuser    OR of tuser over all beats of the word
//   m_axis_tlast    word ends a packet
//   stat_pkts       output words handshaken with tlast=1 (wrapping)
//   stat_words      output words handshaken (wrapping)
// -----------------------------------------------------------------------------
module stream_width_upsizer #(
  parameter int INPUT_WIDTH = 64,
  parameter int RATIO       = 4,
  parameter int USER_WIDTH  = 1,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic [INPUT_WIDTH-1:0]                     s_axis_tdata,
  input  logic [$clog2(INPUT_WIDTH/8)-1:0]           s_axis_tkeep,
  input  logic                                       s_axis_tvalid,
  output logic                                       s_axis_tready,
  input  logic [USER_WIDTH-1:0]                      s_axis_tuser,
  input  logic                                       s_axis_tlast,
  output logic [INPUT_WIDTH*RATIO-1:0]               m_axis_tdata,
  output logic [$clog2(INPUT_WIDTH*RATIO/8)-1:0]     m_axis_tkeep,
  output logic                                       m_axis_tvalid,
  input  logic                                       m_axis_tready,
  output logic [USER_WIDTH-1:0]                      m_axis_tuser,
  output logic                                       m_axis_tlast,
  output logic [CNT_WIDTH-1:0]                       stat_pkts,
  output logic [CNT_WIDTH-1:0]                       stat_words
);

  localparam int IB  = INPUT_WIDTH / 8;      // bytes per input beat
  localparam int OB  = IB * RATIO;           // bytes per output word
  localparam int OKW = $clog2(OB);
  localparam int LW  = $clog2(RATIO);

  if (INPUT_WIDTH < 16 || (INPUT_WIDTH % 8) != 0) begin : g_bad_width
    $error("INPUT_WIDTH must be a multiple of 8 and at least 16");
  end
  if (RATIO < 2 || (RATIO & (RATIO - 1)) != 0) begin : g_bad_ratio
    $error("RATIO must be a power of 2 and at least 2");
  end

  logic [LW-1:0]          lane;
  logic [USER_WIDTH-1:0]  acc_user;
  logic [INPUT_WIDTH-1:0] acc [RATIO-1];

  logic                         accept;
  logic                         closing;
  logic [INPUT_WIDTH*RATIO-1:0] pack;
  logic [OKW-1:0]               keep_next;

  assign s_axis_tready = !m_axis_tvalid || m_axis_tready;
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign closing       = accept && (s_axis_tlast || lane == LW'(RATIO - 1));

  // Word to load on a closing beat: stored lanes below the current lane, the
  // live beat at the current lane, zeros above it.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    pack      = '0;
    keep_next = '0;
    for (int k = 0; k < RATIO - 1; k++) begin
      if (LW'(k) < lane) pack[k*INPUT_WIDTH +: INPUT_WIDTH] = acc[k];
    end
    for (int k = 0; k < RATIO; k++) begin
      if (LW'(k) == lane) pack[k*INPUT_WIDTH +: INPUT_WIDTH] = s_axis_tdata;
    end
    // Byte count of a closing last beat: full lanes before it plus its own
    // bytes; a completely full word wraps to 0 ("all bytes valid").
    if (s_axis_tlast) begin
      keep_next = OKW'((int'(lane) * IB +
                        ((s_axis_tkeep == '0) ? IB : int'(s_axis_tkeep))) % OB);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      lane     <= '0;
      acc_user <= '0;
    end else if (closing) begin
      lane     <= '0;
      acc_user <= '0;
    end else if (accept) begin
      lane     <= lane + LW'(1);
      acc_user <= acc_user | s_axis_tuser;
    end
  end

  // NOTE: accumulator data is not reset; lanes not yet written in a group are masked when the word is loaded.
  always_ff @(posedge clk) begin
    for (int k = 0; k < RATIO - 1; k++) begin
      if (accept && !closing && lane == LW'(k)) acc[k] <= s_axis_tdata;
    end
  end

  // Output stage. A closing beat can only be accepted when the stage is empty
  // or draining this cycle, so a stalled word is never overwritten.
  always_ff @(posedge clk) begin
    if (reset) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tuser  <= '0;
      m_axis_tlast  <= 1'b0;
    end else if (closing) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= pack;
      m_axis_tkeep  <= keep_next;
      m_axis_tuser  <= acc_user | s_axis_tuser;
      m_axis_tlast  <= s_axis_tlast;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_words <= '0;
      stat_pkts  <= '0;
    end else if (m_axis_tvalid && m_axis_tready) begin
      stat_words <= stat_words + CNT_WIDTH'(1);
      if (m_axis_tlast) stat_pkts <= stat_pkts + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_stream_width_upsizer.sv
// -----------------------------------------------------------------------------
// tb_stream_width_upsizer
//   Directed scenarios followed by a randomized phase. A queue-based model of
//   the packer predicts every output word; a negedge monitor compares the DUT
//   against it each cycle. Literal expectations pin the model in the directed
//   scenarios.
// -----------------------------------------------------------------------------
module tb_stream_width_upsizer;

  localparam int IW  = 64;
  localparam int R   = 4;
  localparam int OW  = IW * R;
  localparam int IB  = IW / 8;
  localparam int OB  = IB * R;
  localparam int IKW = 3;
  localparam int OKW = 5;
  localparam int CW  = 32;

  typedef struct packed {
    logic [OW-1:0]  data;
    logic [OKW-1:0] keep;
    logic           user;
    logic           last;
  } word_t;

  logic           clk = 1'b0;
  logic           reset;
  logic [IW-1:0]  s_axis_tdata;
  logic [IKW-1:0] s_axis_tkeep;
  logic           s_axis_tvalid;
  logic           s_axis_tready;
  logic [0:0]     s_axis_tuser;
  logic           s_axis_tlast;
  logic [OW-1:0]  m_axis_tdata;
  logic [OKW-1:0] m_axis_tkeep;
  logic           m_axis_tvalid;
  logic           m_axis_tready;
  logic [0:0]     m_axis_tuser;
  logic           m_axis_tlast;
  logic [CW-1:0]  stat_pkts;
  logic [CW-1:0]  stat_words;

  stream_width_upsizer #(
    .INPUT_WIDTH(IW), .RATIO(R), .USER_WIDTH(1), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .reset(reset),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tuser(s_axis_tuser), .s_axis_tlast(s_axis_tlast),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast),
    .stat_pkts(stat_pkts), .stat_words(stat_words)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int ready_mode = 1;          // 0: hold low, 1: hold high, 2: random
  int out_count  = 0;
  word_t out_log[$];

  // model state
  word_t         exp_q[$];
  logic [OW-1:0] grp_data;
  logic          grp_user;
  int            grp_n;
  int unsigned   exp_words, exp_pkts;

  task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // m_axis_tready driver
  initial forever begin
    @(posedge clk);
    #1;
    case (ready_mode)
      0:       m_axis_tready = 1'b0;
      1:       m_axis_tready = 1'b1;
      default: m_axis_tready = ($urandom_range(0, 9) < 7);
    endcase
  end

  // Model + compare: inputs and m_axis_tready are stable from negedge to the
  // next posedge, so the handshakes of that edge are known here.
  initial forever begin
    @(negedge clk);
    if (reset) begin
      exp_q.delete();
      grp_data  = '0;
      grp_user  = 1'b0;
      grp_n     = 0;
      exp_words = 0;
      exp_pkts  = 0;
    end else begin
      logic  exp_sready;
      word_t w;
      exp_sready = (exp_q.size() == 0) || m_axis_tready;
      check("m_valid", m_axis_tvalid, exp_q.size() != 0);
      check("s_ready", s_axis_tready, exp_sready);
      check("stat_words", stat_words, exp_words);
      check("stat_pkts", stat_pkts, exp_pkts);
      if (exp_q.size() != 0) begin
        check("m_data", m_axis_tdata, exp_q[0].data);
        check("m_keep", m_axis_tkeep, exp_q[0].keep);
        check("m_user", m_axis_tuser, exp_q[0].user);
        check("m_last", m_axis_tlast, exp_q[0].last);
        if (m_axis_tready) begin
          w = exp_q.pop_front();
          out_log.push_back(w);
          out_count++;
          exp_words++;
          if (w.last) exp_pkts++;
        end
      end
      if (s_axis_tvalid && exp_sready) begin
        int nb;
        nb = (s_axis_tkeep == 0) ? IB : int'(s_axis_tkeep);
        grp_data[grp_n*IW +: IW] = s_axis_tdata;
        grp_user = grp_user | s_axis_tuser[0];
        grp_n++;
        if (s_axis_tlast || grp_n == R) begin
          w.data = grp_data;
          w.keep = s_axis_tlast ? OKW'(((grp_n - 1) * IB + nb) % OB) : '0;
          w.user = grp_user;
          w.last = s_axis_tlast;
          exp_q.push_back(w);
          grp_data = '0;
          grp_user = 1'b0;
          grp_n    = 0;
        end
      end
    end
  end

  // Drive one beat, return the number of cycles it waited for s_axis_tready.
  task automatic send_beat(input logic [IW-1:0] d, input logic [IKW-1:0] k,
                           input logic u, input logic l, output int stalls);
    logic ok;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tuser  = u;
    s_axis_tlast  = l;
    stalls = 0;
    forever begin
      @(negedge clk);
      ok = s_axis_tready;
      @(posedge clk);
      #1;
      if (ok) break;
      stalls++;
      if (stalls > 200) begin
        checks++;
        failures++;
        $display("FAIL send_timeout actual=%0d stall cycles", stalls);
        break;
      end
    end
  endtask

  task automatic idle(input int n);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_words(input int target);
    for (int i = 0; i < 200; i++) begin
      if (out_count >= target) return;
      @(posedge clk);
      #2;
    end
    checks++;
    failures++;
    $display("FAIL wait_words actual=%0d required=%0d", out_count, target);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int st, total, base;
    logic [IW-1:0] d [8];

    reset = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tuser  = '0;
    s_axis_tlast  = 1'b0;
    m_axis_tready = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check("rst_m_valid", m_axis_tvalid, 0);
    check("rst_m_data", m_axis_tdata, 0);
    check("rst_m_keep", m_axis_tkeep, 0);
    check("rst_m_user", m_axis_tuser, 0);
    check("rst_m_last", m_axis_tlast, 0);
    check("rst_stat_words", stat_words, 0);
    check("rst_stat_pkts", stat_pkts, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // 1: four beats, no tlast
    base = out_count;
    for (int i = 0; i < 4; i++) d[i] = {16{4'(i + 1)}};
    for (int i = 0; i < 4; i++) send_beat(d[i], 0, 0, 0, st);
    idle(1);
    wait_words(base + 1);
    check("t1_data", out_log[base].data,
          256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111);
    check("t1_keep", out_log[base].keep, 0);
    check("t1_last", out_log[base].last, 0);
    check("t1_stat_words", stat_words, 1);

    // 2: six-beat packet, last beat has 3 bytes
    base = out_count;
    for (int i = 0; i < 6; i++) d[i] = 64'h00A0_0000_0000_0000 | 64'(i);
    for (int i = 0; i < 6; i++) send_beat(d[i], (i == 5) ? 3'd3 : 3'd0, 0, i == 5, st);
    idle(1);
    wait_words(base + 2);
    check("t2_w1_keep", out_log[base].keep, 0);
    check("t2_w1_last", out_log[base].last, 0);
    check("t2_w2_data", out_log[base+1].data,
          256'h0_0000000000000000_0000000000000000_00A0000000000005_00A0000000000004);
    check("t2_w2_keep", out_log[base+1].keep, 11);
    check("t2_w2_last", out_log[base+1].last, 1);
    check("t2_stat_pkts", stat_pkts, 1);

    // 3: single-beat packet, then a back-to-back 4-beat packet
    base = out_count;
    total = 0;
    send_beat(64'hDEAD_BEEF_0123_4567, 5, 0, 1, st);
    for (int i = 0; i < 4; i++) begin
      send_beat({$urandom, $urandom}, 0, 0, i == 3, st);
      total += st;
    end
    idle(1);
    wait_words(base + 2);
    check("t3_b2b_stalls", total, 0);
    check("t3_data", out_log[base].data, 256'hDEAD_BEEF_0123_4567);
    check("t3_keep", out_log[base].keep, 5);
    check("t3_last", out_log[base].last, 1);
    check("t3_full_keep", out_log[base+1].keep, 0);

    // 4: output stalled for 10 cycles with a word pending
    base = out_count;
    ready_mode = 0;
    for (int i = 0; i < 8; i++) d[i] = {8{8'(8'h10 + i)}};
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) send_beat(d[i], 0, 0, 0, st);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d[4];
    s_axis_tkeep  = '0;
    s_axis_tuser  = '0;
    s_axis_tlast  = 1'b0;
    repeat (10) begin
      @(posedge clk);
      #2;
      check("t4_s_ready", s_axis_tready, 0);
      check("t4_m_valid", m_axis_tvalid, 1);
    end
    ready_mode = 1;
    for (int i = 4; i < 8; i++) send_beat(d[i], (i == 7) ? 3'd4 : 3'd0, 0, i == 7, st);
    idle(1);
    wait_words(base + 2);
    check("t4_w1_data", out_log[base].data, {d[3], d[2], d[1], d[0]});
    check("t4_w2_data", out_log[base+1].data, {d[7], d[6], d[5], d[4]});
    check("t4_w2_keep", out_log[base+1].keep, 28);

    // 5: tuser on beat 2 only, then a clean word
    base = out_count;
    for (int i = 0; i < 8; i++) send_beat({$urandom, $urandom}, 0, i == 2, 0, st);
    idle(1);
    wait_words(base + 2);
    check("t5_user_set", out_log[base].user, 1);
    check("t5_user_clear", out_log[base+1].user, 0);

    // 6: reset after two accepted beats
    send_beat(64'hAAAA_AAAA_AAAA_AAAA, 0, 1, 0, st);
    send_beat(64'hBBBB_BBBB_BBBB_BBBB, 0, 0, 0, st);
    s_axis_tvalid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #2;
    check("t6_m_valid", m_axis_tvalid, 0);
    check("t6_stat_words", stat_words, 0);
    check("t6_stat_pkts", stat_pkts, 0);
    check("t6_m_data", m_axis_tdata, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    base = out_count;
    for (int i = 0; i < 4; i++) d[i] = {4{16'(16'hC000 + i)}};
    for (int i = 0; i < 4; i++) send_beat(d[i], 0, 0, 0, st);
    idle(1);
    wait_words(base + 1);
    check("t6_data", out_log[base].data,
          256'hC003C003C003C003_C002C002C002C002_C001C001C001C001_C000C000C000C000);
    check("t6_user", out_log[base].user, 0);
    check("t6_stat_words", stat_words, 1);

    // randomized traffic with random backpressure
    ready_mode = 2;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      send_beat({$urandom, $urandom}, IKW'($urandom_range(0, 7)),
                ($urandom_range(0, 7) == 0), (i == 399) || ($urandom_range(0, 4) == 0), st);
    end
    ready_mode = 1;
    idle(20);
    check("drain_queue_empty", exp_q.size(), 0);
    check("drain_group_empty", grp_n, 0);
    check("drain_m_valid", m_axis_tvalid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
